dp_arbiter: RTL and testbench
=============================

# dp_arbiter

Arbitrates the shared ALU/register datapath (A, B and R registers, ALU select) between the three clock controllers: time update, timer compare and timer set. Each controller raises a request and presents its control word. The arbiter grants one controller at a time, muxes the winner's control word onto the datapath control lines, and inserts a one-cycle idle turnaround between owners. Time update always wins, so the seconds tick is never lost.

## Interface
- HOLD_MAX, default 64: maximum cycles a grant may be held; used only with timeout compiled in; legal range 2..255.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  3  request; bit0 = time update, bit1 = timer compare, bit2 = timer set
- cw0  in  8  time-update control word {s[1:0],Kc,Er,Lr,Ea,Lb,La} (bit7..bit0)
- cw1  in  8  timer-compare control word, same layout
- cw2  in  8  timer-set control word, same layout
- gnt  out 3  one-hot grant, same bit order as req
- La, Lb, Ea, Lr, Er, Kc  out 1 each  datapath controls from the granted word
- s  out 2  ALU select from the granted word
- busy  out 1  high while any grant is active
- timeout  out 1  one-cycle pulse when a grant is revoked by the hold timer

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: exactly one gnt bit set.
  - RELEASE: one turnaround cycle with no grant.
- IDLE → GRANT when req != 0; the winner is latched into gnt.
- GRANT → RELEASE when req[owner] is low at a clock edge, or on timeout.
- RELEASE → GRANT when any eligible req is high at that edge; otherwise RELEASE → IDLE.
- Priority:
  - req[0] always wins.
  - Between req[1] and req[2], rotating priority applies: on a tie, the one not granted most recently wins.
  - The pointer is reset to favour req[1].
- Control outputs equal the granted cw, passed combinationally through a mux. With no grant (IDLE, RELEASE, reset), all control outputs and s are 0.
- busy = |gnt.
- A requester is never pre-empted by a higher-priority request. It keeps the grant until it drops req (or times out).

## Timing
- Reset values: gnt=0, busy=0, timeout=0, all controls 0, state IDLE, rotation pointer favours req[1].
- rst is asynchronous and clears everything immediately, including mid-GRANT. The first grant can occur at the first edge after rst deasserts with req high.
- Grant latency: req sampled high at edge n → gnt high during cycle n+1.
- Release: req[owner] sampled low at edge n → gnt=0 during cycle n+1 (RELEASE). The next grant is visible during cycle n+2 at the earliest.
- Minimum gap between two owners: exactly one idle cycle.
- Simultaneous events:
  - Owner drops req while another raises req at the same edge: RELEASE, then the other is granted.
  - All three request together: req[0] first, then rotation decides between 1 and 2.
- A cw change during GRANT propagates to the outputs in the same cycle; there is no registering.

## Configuration
- DP_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches HOLD_MAX-1, the next edge forces RELEASE and timeout pulses high for that RELEASE cycle.
  - The revoked requester is masked from arbitration until it drops its req for at least one edge.
- DP_ARB_TIMEOUT_EN not defined:
  - No counter and no mask logic.
  - timeout is tied 0.
  - A grant is held indefinitely while req[owner] stays high.

## Structure
- Shared package dp_arb_pkg holds:
  - state encodings IDLE/GRANT/RELEASE;
  - requester indices REQ_UPD=0, REQ_CMP=1, REQ_SET=2;
  - control-word bit indices CW_LA=0 … CW_S_LO=6, CW_S_HI=7.
- One sub-module, arb_hold_timer: counter plus expiry compare, instantiated only under DP_ARB_TIMEOUT_EN.
- Top level contains the FSM, priority/rotation logic, the mask, and the output mux.

## Test plan
- Reset mid-GRANT: req=3'b001, cw0=8'hA5 granted; assert rst → gnt=0 and all controls 0 immediately. After release with req still high → gnt=001 one edge later.
- Single owner: req=3'b010 at edge 1 → gnt=010 and {s,Kc,Er,Lr,Ea,Lb,La}=cw1 from cycle 2. Drop req at edge 5 → gnt=0 and controls 0 in cycle 6, state IDLE in cycle 7.
- Priority: req=3'b111 → gnt=001. Release → one idle cycle → gnt=010. Release → idle → gnt=100.
- Rotation: req[1] and req[2] both held and alternately released/re-raised → grants alternate 010,100,010 with one idle cycle between each.
- Handover: owner 001 drops req in the same cycle req[2] rises → RELEASE (gnt=0) one cycle, then gnt=100.
- Timeout (DP_ARB_TIMEOUT_EN, HOLD_MAX=4): req=3'b100 held → gnt=100 for 4 cycles, then timeout=1 with gnt=0. req[2] stays masked until it drops; with req[1] pending → gnt=010 next.

Source files
------------

// File: rtl/dp_arb_pkg.sv
// Shared definitions for the datapath arbiter: FSM state encodings,
// requester indices and control-word bit positions.
package dp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int unsigned REQ_W  = 3;
    localparam int unsigned CW_W   = 8;
    localparam int unsigned HOLD_W = 8;

    // Requester indices (bit positions in req/gnt)
    localparam int unsigned REQ_UPD = 0;
    localparam int unsigned REQ_CMP = 1;
    localparam int unsigned REQ_SET = 2;

    // Control-word layout {s[1:0],Kc,Er,Lr,Ea,Lb,La}
    localparam int unsigned CW_LA   = 0;
    localparam int unsigned CW_LB   = 1;
    localparam int unsigned CW_EA   = 2;
    localparam int unsigned CW_LR   = 3;
    localparam int unsigned CW_ER   = 4;
    localparam int unsigned CW_KC   = 5;
    localparam int unsigned CW_S_LO = 6;
    localparam int unsigned CW_S_HI = 7;

endpackage

// File: rtl/arb_hold_timer.sv
// Grant hold timer: counts GRANT cycles and flags the last permitted one.
//   clk, rst  : clock, async active-high reset
//   en        : high while a grant is held; low clears the count
//   expire_c  : combinational, high during the HOLD_MAX-th GRANT cycle
module arb_hold_timer
    import dp_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expire_c
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_MAX - 1);

    logic [HOLD_W-1:0] count;

    // Clearing whenever idle guarantees a zero count on entry to GRANT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + HOLD_W'(1);
        end else begin
            count <= '0;
        end
    end

    assign expire_c = en && (count == LAST);

endmodule

// File: rtl/dp_arbiter.sv
// Arbitrates the shared ALU/register datapath between the time-update,
// timer-compare and timer-set controllers, with a one-cycle turnaround
// between owners. Time update has fixed top priority; compare and set
// rotate. Optional grant hold timeout: define DP_ARB_TIMEOUT_EN.
//   clk, rst           : clock, async active-high reset
//   req[2:0]           : requests {set, compare, update}
//   cw0, cw1, cw2      : control words of the three requesters
//   gnt[2:0]           : one-hot registered grant
//   La,Lb,Ea,Lr,Er,Kc,s: granted control word (combinational mux, 0 if none)
//   busy               : any grant active
//   timeout            : one-cycle pulse when the hold timer revokes a grant
module dp_arbiter
    import dp_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] cw0,
    input  logic [7:0] cw1,
    input  logic [7:0] cw2,
    output logic [2:0] gnt,
    output logic       La,
    output logic       Lb,
    output logic       Ea,
    output logic       Lr,
    output logic       Er,
    output logic       Kc,
    output logic [1:0] s,
    output logic       busy,
    output logic       timeout
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("dp_arbiter: HOLD_MAX must be in 2..255");
    end

    state_t          state, state_next;
    logic [REQ_W-1:0] gnt_next;
    logic [REQ_W-1:0] eligible;
    logic [REQ_W-1:0] winner;
    logic             fav_set, fav_set_next;  // 1: timer set wins a compare/set tie
    logic             expire;
    logic [CW_W-1:0]  cw_sel;

`ifdef DP_ARB_TIMEOUT_EN
    logic [REQ_W-1:0] mask, mask_next;
    logic             hold_en;

    assign hold_en = (state == GRANT);

    arb_hold_timer #(.HOLD_MAX(HOLD_MAX)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (hold_en),
        .expire_c (expire)
    );

    // A revoked owner stays masked until it has dropped req at an edge
    always_comb begin
        mask_next = (mask | (expire ? gnt : 3'b000)) & req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask    <= '0;
            timeout <= 1'b0;
        end else begin
            mask    <= mask_next;
            timeout <= expire;
        end
    end

    assign eligible = req & ~mask;
`else
    assign expire   = 1'b0;
    assign timeout  = 1'b0;
    assign eligible = req;
`endif

    // Fixed priority for update, rotating tie-break between compare and set
    always_comb begin
        winner = '0;
        if (eligible[REQ_UPD]) begin
            winner[REQ_UPD] = 1'b1;
        end else if (eligible[REQ_CMP] && (!eligible[REQ_SET] || !fav_set)) begin
            winner[REQ_CMP] = 1'b1;
        end else if (eligible[REQ_SET]) begin
            winner[REQ_SET] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            fav_set <= 1'b0;
        end else begin
            state   <= state_next;
            gnt     <= gnt_next;
            fav_set <= fav_set_next;
        end
    end

    // Next-state / grant logic
    always_comb begin
        state_next   = state;
        gnt_next     = gnt;
        fav_set_next = fav_set;
        case (state)
            IDLE, RELEASE: begin
                if (|eligible) begin
                    state_next = GRANT;
                    gnt_next   = winner;
                    if (winner[REQ_CMP]) begin
                        fav_set_next = 1'b1;
                    end else if (winner[REQ_SET]) begin
                        fav_set_next = 1'b0;
                    end
                end else begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end
            end
            GRANT: begin
                if (!(|(req & gnt)) || expire) begin
                    state_next = RELEASE;
                    gnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // One-hot AND-OR mux; zero when no grant is held
    always_comb begin
        cw_sel = ({CW_W{gnt[REQ_UPD]}} & cw0)
               | ({CW_W{gnt[REQ_CMP]}} & cw1)
               | ({CW_W{gnt[REQ_SET]}} & cw2);
    end

    assign La   = cw_sel[CW_LA];
    assign Lb   = cw_sel[CW_LB];
    assign Ea   = cw_sel[CW_EA];
    assign Lr   = cw_sel[CW_LR];
    assign Er   = cw_sel[CW_ER];
    assign Kc   = cw_sel[CW_KC];
    assign s    = cw_sel[CW_S_HI:CW_S_LO];
    assign busy = |gnt;

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed self-checking bench for dp_arbiter (HOLD_MAX = 4).
module tb_dp_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] cw0, cw1, cw2;
    logic [2:0] gnt;
    logic       La, Lb, Ea, Lr, Er, Kc;
    logic [1:0] s;
    logic       busy, timeout;
    logic [7:0] ctl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dp_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .cw0     (cw0),
        .cw1     (cw1),
        .cw2     (cw2),
        .gnt     (gnt),
        .La      (La),
        .Lb      (Lb),
        .Ea      (Ea),
        .Lr      (Lr),
        .Er      (Er),
        .Kc      (Kc),
        .s       (s),
        .busy    (busy),
        .timeout (timeout)
    );

    assign ctl = {s, Kc, Er, Lr, Ea, Lb, La};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Grant, busy, control word and timeout in one go
    task automatic expect_out(input string tag, input logic [2:0] g, input logic [7:0] c,
                              input logic to);
        check({tag, "_gnt"}, 8'(gnt), 8'(g));
        check({tag, "_busy"}, 8'(busy), 8'(|g));
        check({tag, "_ctl"}, ctl, c);
        check({tag, "_to"}, 8'(timeout), 8'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        cw0 = 8'hA5;
        cw1 = 8'h3C;
        cw2 = 8'h5A;
        #12;
        expect_out("reset", 3'b000, 8'h00, 1'b0);

        // Reset mid-GRANT
        tick();
        rst = 1'b0;
        req = 3'b001;
        tick();
        expect_out("upd_grant", 3'b001, 8'hA5, 1'b0);
        #2 rst = 1'b1;
        #1 expect_out("async_rst", 3'b000, 8'h00, 1'b0);
        tick();
        expect_out("in_rst", 3'b000, 8'h00, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("post_rst", 3'b001, 8'hA5, 1'b0);
        req = 3'b000;
        tick();
        expect_out("post_rst_rel", 3'b000, 8'h00, 1'b0);
        tick();

        // Priority: all three request
        req = 3'b111;
        tick();
        expect_out("pri_upd", 3'b001, 8'hA5, 1'b0);
        req = 3'b110;
        tick();
        expect_out("pri_rel0", 3'b000, 8'h00, 1'b0);
        tick();
        expect_out("pri_cmp", 3'b010, 8'h3C, 1'b0);
        req = 3'b100;
        tick();
        expect_out("pri_rel1", 3'b000, 8'h00, 1'b0);
        tick();
        expect_out("pri_set", 3'b100, 8'h5A, 1'b0);
        req = 3'b000;
        tick();
        tick();

        // Rotation between compare and set
        req = 3'b110;
        tick();
        expect_out("rot_a", 3'b010, 8'h3C, 1'b0);
        req = 3'b100;
        tick();
        expect_out("rot_rel_a", 3'b000, 8'h00, 1'b0);
        req = 3'b110;
        tick();
        expect_out("rot_b", 3'b100, 8'h5A, 1'b0);
        req = 3'b010;
        tick();
        expect_out("rot_rel_b", 3'b000, 8'h00, 1'b0);
        req = 3'b110;
        tick();
        expect_out("rot_c", 3'b010, 8'h3C, 1'b0);
        req = 3'b000;
        tick();
        tick();
        expect_out("rot_idle", 3'b000, 8'h00, 1'b0);

        // Single owner with a live control-word change
        req = 3'b010;
        tick();
        expect_out("single", 3'b010, 8'h3C, 1'b0);
        cw1 = 8'hC3;
        #1 check("cw_comb", ctl, 8'hC3);
        tick();
        expect_out("single_hold", 3'b010, 8'hC3, 1'b0);
        req = 3'b000;
        tick();
        expect_out("single_rel", 3'b000, 8'h00, 1'b0);
        tick();
        expect_out("single_idle", 3'b000, 8'h00, 1'b0);
        cw1 = 8'h3C;

        // Handover: owner drops while set rises at the same edge
        req = 3'b001;
        tick();
        expect_out("ho_upd", 3'b001, 8'hA5, 1'b0);
        req = 3'b100;
        tick();
        expect_out("ho_gap", 3'b000, 8'h00, 1'b0);
        tick();
        expect_out("ho_set", 3'b100, 8'h5A, 1'b0);
        req = 3'b000;
        tick();
        tick();

`ifdef DP_ARB_TIMEOUT_EN
        // Hold timer revokes after 4 cycles, owner masked until it drops
        req = 3'b100;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out($sformatf("to_hold%0d", i), 3'b100, 8'h5A, 1'b0);
        end
        req = 3'b110;
        tick();
        expect_out("to_pulse", 3'b000, 8'h00, 1'b1);
        tick();
        expect_out("to_next", 3'b010, 8'h3C, 1'b0);
        req = 3'b100;
        tick();
        expect_out("to_rel", 3'b000, 8'h00, 1'b0);
        tick();
        expect_out("to_masked", 3'b000, 8'h00, 1'b0);
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        expect_out("to_unmasked", 3'b100, 8'h5A, 1'b0);
`else
        // Without the timer a grant is held indefinitely
        req = 3'b100;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out($sformatf("hold%0d", i), 3'b100, 8'h5A, 1'b0);
        end
`endif
        req = 3'b000;
        tick();
        tick();
        expect_out("final_idle", 3'b000, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
